// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the nibble-to-glyph decode.
// Glyph patterns are active-high, with bit order [6]=a ... [0]=g.
package seg7_pkg;

  localparam int unsigned SEG7_W     = 7;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [SEG7_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG7_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG7_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG7_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG7_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG7_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG7_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG7_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG7_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG7_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG7_W-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEG7_W-1:0] SEG_B     = 7'b0011111;
  localparam logic [SEG7_W-1:0] SEG_C     = 7'b1001110;
  localparam logic [SEG7_W-1:0] SEG_D     = 7'b0111101;
  localparam logic [SEG7_W-1:0] SEG_E     = 7'b1001111;
  localparam logic [SEG7_W-1:0] SEG_F     = 7'b1000111;
  localparam logic [SEG7_W-1:0] SEG_BLANK = 7'b0000000;

  // Active-high glyph for a nibble; values above 9 go blank when hex_mode is 0.
  function automatic logic [SEG7_W-1:0] seg7_decode(input logic [NIBBLE_W-1:0] nibble,
                                                    input logic                hex_mode);
    logic [SEG7_W-1:0] pat;
    pat = SEG_BLANK;
    case (nibble)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      4'hF: pat = SEG_F;
    endcase
    if (!hex_mode && (nibble > 4'd9)) pat = SEG_BLANK;
    return pat;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational nibble -> active-high segment pattern.
// Ports: nibble (digit value), pattern_c (abcdefg, 1 = lit).
module seg7_glyph_rom
  import seg7_pkg::*;
#(
  parameter int unsigned HEX_MODE = 1
) (
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG7_W-1:0]   pattern_c
);

  assign pattern_c = seg7_decode(nibble, HEX_MODE != 0);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed multi-digit seven-segment driver.
// Ports: CLOCK_50/reset_n clock and async active-low reset; enable gates scanning;
// load captures value/dp_in into shadow registers; blank_lz enables leading-zero
// blanking; seg_output/dp_out/digit_sel drive the display; frame_done pulses on wrap.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned HEX_MODE       = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned SEL_ACTIVE_LOW = 1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         load,
  input  logic [NIBBLE_W*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]            dp_in,
  input  logic                         blank_lz,
  output logic [SEG7_W-1:0]            seg_output,
  output logic                         dp_out,
  output logic [DIGITS-1:0]            digit_sel,
  output logic                         frame_done
);

  localparam int unsigned VAL_W = NIBBLE_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [SEG7_W-1:0] SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic              DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] SEL_OFF  = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [VAL_W-1:0]    shadow_val, val_eff;
  logic [DIGITS-1:0]   shadow_dp, dp_eff;
  logic [CNT_W-1:0]    count, count_nxt;
  logic [IDX_W-1:0]    index, index_nxt, idx_new;
  logic                enable_q;
  logic                start_c, tick_c, update_c;
  logic [NIBBLE_W-1:0] nib_c;
  logic                dp_sel_c, upper_nonzero_c, lz_blank_c, hex_blank_c;
  logic [DIGITS-1:0]   sel_onehot_c;
  logic [SEG7_W-1:0]   glyph_c, seg_hi_c;
  logic                dp_hi_c;
  logic [SEG7_W-1:0]   seg_nxt;
  logic                dp_nxt;
  logic [DIGITS-1:0]   sel_nxt;
  logic                frame_nxt;

  // Digit selection: a load on the update edge is forwarded so the new value shows at once.
  always_comb begin
    val_eff         = load ? value : shadow_val;
    dp_eff          = load ? dp_in : shadow_dp;
    start_c         = enable & ~enable_q;
    tick_c          = enable & ~start_c & (count == LAST_CNT);
    update_c        = start_c | tick_c;
    nib_c           = '0;
    dp_sel_c        = 1'b0;
    sel_onehot_c    = '0;
    upper_nonzero_c = 1'b0;

    if (start_c || (index == LAST_IDX)) idx_new = '0;
    else                                idx_new = index + IDX_W'(1);

    for (int j = 0; j < DIGITS; j++) begin
      if (IDX_W'(j) == idx_new) begin
        nib_c           = val_eff[j*NIBBLE_W +: NIBBLE_W];
        dp_sel_c        = dp_eff[j];
        sel_onehot_c[j] = 1'b1;
      end
      // Any non-zero nibble at or above the new digit keeps it from being a leading zero.
      if ((IDX_W'(j) >= idx_new) && (val_eff[j*NIBBLE_W +: NIBBLE_W] != '0))
        upper_nonzero_c = 1'b1;
    end
  end

  seg7_glyph_rom #(
    .HEX_MODE (HEX_MODE)
  ) u_glyph_rom (
    .nibble    (nib_c),
    .pattern_c (glyph_c)
  );

  // Next-state and output update; outputs only change on start/tick or when disabled.
  always_comb begin
    lz_blank_c  = blank_lz && (idx_new != '0) && !upper_nonzero_c;
    hex_blank_c = (HEX_MODE == 0) && (nib_c > 4'd9);
    seg_hi_c    = lz_blank_c ? SEG_BLANK : glyph_c;
    dp_hi_c     = dp_sel_c && !lz_blank_c && !hex_blank_c;

    count_nxt = count;
    index_nxt = index;
    seg_nxt   = seg_output;
    dp_nxt    = dp_out;
    sel_nxt   = digit_sel;
    frame_nxt = 1'b0;

    if (!enable) begin
      count_nxt = '0;
      index_nxt = '0;
      seg_nxt   = SEG_OFF;
      dp_nxt    = DP_OFF;
      sel_nxt   = SEL_OFF;
    end else if (update_c) begin
      count_nxt = '0;
      index_nxt = idx_new;
      seg_nxt   = (SEG_ACTIVE_LOW != 0) ? ~seg_hi_c : seg_hi_c;
      dp_nxt    = (SEG_ACTIVE_LOW != 0) ? ~dp_hi_c : dp_hi_c;
      sel_nxt   = (SEL_ACTIVE_LOW != 0) ? ~sel_onehot_c : sel_onehot_c;
      frame_nxt = tick_c && (index == LAST_IDX);
    end else begin
      count_nxt = count + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      count      <= '0;
      index      <= '0;
      enable_q   <= 1'b0;
      seg_output <= SEG_OFF;
      dp_out     <= DP_OFF;
      digit_sel  <= SEL_OFF;
      frame_done <= 1'b0;
    end else begin
      shadow_val <= val_eff;
      shadow_dp  <= dp_eff;
      count      <= count_nxt;
      index      <= index_nxt;
      enable_q   <= enable;
      seg_output <= seg_nxt;
      dp_out     <= dp_nxt;
      digit_sel  <= sel_nxt;
      frame_done <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench: hex and decimal-only instances driven in parallel, compared
// against directed tables, hand sequences and a cycle-count based reference model.
module tb_seven_segment_scanner;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned RDIV   = 4;

  // Active-low glyphs, abcdefg.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] BL = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0, load = 1'b0, blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg1, seg0;
  logic        dp1, dp0, fd1, fd0;
  logic [3:0]  sel1, sel0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .HEX_MODE(1),
                          .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg_output(seg1), .dp_out(dp1),
    .digit_sel(sel1), .frame_done(fd1));

  seven_segment_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .HEX_MODE(0),
                          .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut_dec (
    .CLOCK_50(clk), .reset_n(reset_n), .enable(enable), .load(load), .value(value),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg_output(seg0), .dp_out(dp0),
    .digit_sel(sel0), .frame_done(fd0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_seg"}, 32'(seg1), 32'(BL));
    chk({tag, "_dp"},  32'(dp1),  32'(1));
    chk({tag, "_sel"}, 32'(sel1), 32'(4'hF));
    chk({tag, "_fd"},  32'(fd1),  32'(0));
    chk({tag, "_seg_dec"}, 32'(seg0), 32'(BL));
  endtask

  // Expected active-low outputs for digit d of a value, straight from the display rules.
  function automatic void expect_digit(input int val, input int dpv, input bit blz, input int d,
                                       input bit hex, output logic [6:0] seg,
                                       output logic dp, output logic [3:0] sel);
    int nib;
    bit lz, hb;
    nib = (val >> (4 * d)) & 15;
    lz  = blz && (d > 0) && ((val >> (4 * d)) == 0);
    hb  = !hex && (nib > 9);
    seg = (lz || hb) ? BL : GLYPH[nib];
    dp  = (lz || hb) ? 1'b1 : (((dpv >> d) & 1) == 0);
    sel = 4'hF ^ 4'(1 << d);
  endfunction

  // Reference model: time since the enable start edge picks the digit and the update edges.
  int         m_shadow = 0, m_dp = 0, m_t = 0;
  bit         m_en_q = 1'b0;
  logic [6:0] e_seg1 = BL, e_seg0 = BL;
  logic       e_dp1 = 1'b1, e_dp0 = 1'b1, e_fd = 1'b0;
  logic [3:0] e_sel = 4'hF;

  always @(posedge clk or negedge reset_n) begin : model_blk
    int ev, edp, t, d;
    logic [6:0] s;
    logic p;
    logic [3:0] sl;
    if (!reset_n) begin
      m_shadow <= 0; m_dp <= 0; m_en_q <= 1'b0; m_t <= 0;
      e_seg1 <= BL; e_seg0 <= BL; e_dp1 <= 1'b1; e_dp0 <= 1'b1; e_sel <= 4'hF; e_fd <= 1'b0;
    end else begin
      ev  = load ? int'(value) : m_shadow;
      edp = load ? int'(dp_in) : m_dp;
      e_fd <= 1'b0;
      if (!enable) begin
        m_t <= 0;
        e_seg1 <= BL; e_seg0 <= BL; e_dp1 <= 1'b1; e_dp0 <= 1'b1; e_sel <= 4'hF;
      end else begin
        t = m_en_q ? m_t + 1 : 0;
        m_t <= t;
        if ((t % RDIV) == 0) begin
          d = (t / RDIV) % DIGITS;
          e_fd <= (t != 0) && ((t % (RDIV * DIGITS)) == 0);
          expect_digit(ev, edp, blank_lz, d, 1'b1, s, p, sl);
          e_seg1 <= s; e_dp1 <= p; e_sel <= sl;
          expect_digit(ev, edp, blank_lz, d, 1'b0, s, p, sl);
          e_seg0 <= s; e_dp0 <= p;
        end
      end
      m_en_q <= enable; m_shadow <= ev; m_dp <= edp;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("mdl_seg_hex", 32'(seg1), 32'(e_seg1));
      chk("mdl_dp_hex",  32'(dp1),  32'(e_dp1));
      chk("mdl_sel_hex", 32'(sel1), 32'(e_sel));
      chk("mdl_fd_hex",  32'(fd1),  32'(e_fd));
      chk("mdl_seg_dec", 32'(seg0), 32'(e_seg0));
      chk("mdl_dp_dec",  32'(dp0),  32'(e_dp0));
      chk("mdl_sel_dec", 32'(sel0), 32'(e_sel));
      chk("mdl_fd_dec",  32'(fd0),  32'(e_fd));
    end
  end

  typedef struct packed {
    logic [15:0]     val;
    logic [3:0]      dp;
    logic            blz;
    logic [3:0][6:0] s1;
    logic [3:0]      d1;
    logic [3:0][6:0] s0;
    logic [3:0]      d0;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int fd_cnt, fd_first;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, {GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4]}, 4'b1111,
                {GLYPH[1], GLYPH[2], GLYPH[3], GLYPH[4]}, 4'b1111};
    vecs[1] = '{16'h0070, 4'b0000, 1'b1, {BL, BL, GLYPH[7], GLYPH[0]}, 4'b1111,
                {BL, BL, GLYPH[7], GLYPH[0]}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b1111, 1'b1, {BL, BL, BL, GLYPH[0]}, 4'b1110,
                {BL, BL, BL, GLYPH[0]}, 4'b1110};
    vecs[3] = '{16'h00AF, 4'b0001, 1'b0, {GLYPH[0], GLYPH[0], GLYPH[10], GLYPH[15]}, 4'b1110,
                {GLYPH[0], GLYPH[0], BL, BL}, 4'b1111};
    vecs[4] = '{16'h00AF, 4'b0110, 1'b1, {BL, BL, GLYPH[10], GLYPH[15]}, 4'b1101,
                {BL, BL, BL, BL}, 4'b1111};
    vecs[5] = '{16'h8E5B, 4'b1111, 1'b1, {GLYPH[8], GLYPH[14], GLYPH[5], GLYPH[11]}, 4'b0000,
                {GLYPH[8], BL, GLYPH[5], BL}, 4'b0101};

    // Reset, then stay dark while disabled.
    repeat (3) tick();
    chk_off("reset");
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (3) tick();
    chk_off("idle");

    // Static digit tables.
    for (int i = 0; i < 6; i++) begin
      enable = 1'b0; tick();
      load = 1'b1; value = vecs[i].val; dp_in = vecs[i].dp; blank_lz = vecs[i].blz; tick();
      load = 1'b0; tick();
      enable = 1'b1; tick();
      for (int k = 0; k < 4; k++) begin
        if (k > 0) repeat (RDIV) tick();
        chk($sformatf("vec%0d_d%0d_seg_hex", i, k), 32'(seg1), 32'(vecs[i].s1[k]));
        chk($sformatf("vec%0d_d%0d_dp_hex", i, k),  32'(dp1),  32'(vecs[i].d1[k]));
        chk($sformatf("vec%0d_d%0d_sel", i, k),     32'(sel1), 32'(4'hF ^ 4'(1 << k)));
        chk($sformatf("vec%0d_d%0d_seg_dec", i, k), 32'(seg0), 32'(vecs[i].s0[k]));
        chk($sformatf("vec%0d_d%0d_dp_dec", i, k),  32'(dp0),  32'(vecs[i].d0[k]));
      end
    end

    // Async reset in the middle of a scan, released while disabled.
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    chk_off("async_rst");
    tick();
    enable = 1'b0; reset_n = 1'b1;
    repeat (3) tick();
    chk_off("post_rst");

    // frame_done: one pulse per 16 cycles, first at the wrap.
    value = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0; load = 1'b1; tick(); load = 1'b0;
    enable = 1'b1; tick();
    chk("start_seg", 32'(seg1), 32'(GLYPH[4]));
    chk("start_sel", 32'(sel1), 32'(4'b1110));
    fd_cnt = 0; fd_first = -1;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (fd1 === 1'b1) begin
        fd_cnt++;
        if (fd_first < 0) fd_first = c;
      end
    end
    chk("fd_count", 32'(fd_cnt), 32'(2));
    chk("fd_first", 32'(fd_first), 32'(16));

    // Load mid-digit holds the display; load coincident with tick shows the new value.
    enable = 1'b0; tick();
    enable = 1'b1; tick();              // t=0
    repeat (4) tick();                  // t=4, digit 1
    chk("mid_d1_seg", 32'(seg1), 32'(GLYPH[3]));
    repeat (2) tick();                  // t=6
    value = 16'h5678; load = 1'b1; tick(); load = 1'b0;  // t=7
    chk("mid_hold_seg", 32'(seg1), 32'(GLYPH[3]));
    chk("mid_hold_sel", 32'(sel1), 32'(4'b1101));
    tick();                             // t=8, digit 2 of new value
    chk("mid_new_seg", 32'(seg1), 32'(GLYPH[6]));
    repeat (3) tick();                  // t=11
    value = 16'h9ABC; load = 1'b1; tick(); load = 1'b0;  // t=12, load on tick
    chk("coinc_seg", 32'(seg1), 32'(GLYPH[9]));
    chk("coinc_sel", 32'(sel1), 32'(4'b0111));

    // Disable just before the wrap: dark, no frame_done; restart from digit 0.
    repeat (3) tick();                  // t=15
    enable = 1'b0; tick();
    chk_off("dis");
    tick();
    chk("dis_fd", 32'(fd1), 32'(0));
    enable = 1'b1; tick();
    chk("re_seg", 32'(seg1), 32'(GLYPH[12]));
    chk("re_sel", 32'(sel1), 32'(4'b1110));
    repeat (3) tick();
    chk("re_hold_seg", 32'(seg1), 32'(GLYPH[12]));
    tick();
    chk("re_adv_seg", 32'(seg1), 32'(GLYPH[11]));
    chk("re_adv_sel", 32'(sel1), 32'(4'b1101));

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0; #1; reset_n = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
